// File: rtl/reg_file_pkg.sv
// reg_file_pkg: default geometry, reset constants and word type shared by the register file and its users.
package reg_file_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_NREGS = 2;
    localparam logic [DEF_WIDTH-1:0] DEF_RST_VAL0 = 16'h00A5;
    localparam logic [DEF_WIDTH-1:0] DEF_RST_VAL1 = 16'h5A00;
    typedef logic [DEF_WIDTH-1:0] word_t;
endpackage

// File: rtl/reg_file.sv
// reg_file: two-read/one-write register file with combinational reads and async active-low reset.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREGS = DEF_NREGS,
    parameter logic [WIDTH-1:0] RST_VAL0 = WIDTH'(DEF_RST_VAL0),
    parameter logic [WIDTH-1:0] RST_VAL1 = WIDTH'(DEF_RST_VAL1),
    localparam int AW = (NREGS > 2) ? $clog2(NREGS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    AA1,
    input  logic [AW-1:0]    BA1,
    input  logic             WE,
    input  logic [AW-1:0]    DA,
    input  logic [WIDTH-1:0] D_data,
    output logic [WIDTH-1:0] A_data,
    output logic [WIDTH-1:0] B_data
);
    logic [WIDTH-1:0] regs [NREGS];
    logic [1:0]       wr_sync;

    always_comb begin
        A_data = (32'(AA1) < NREGS) ? regs[AA1] : '0;
        B_data = (32'(BA1) < NREGS) ? regs[BA1] : '0;
    end

    // Writes stay blocked until the release of reset has passed through two flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_sync <= '0;
            for (int i = 0; i < NREGS; i++)
                regs[i] <= (i == 0) ? RST_VAL0 : (i == 1) ? RST_VAL1 : '0;
        end else begin
            wr_sync <= {wr_sync[0], 1'b1};
            if (WE && wr_sync[1] && (32'(DA) < NREGS))
                regs[DA] <= D_data;
        end
    end
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed and random checks of reg_file against an array model.
module tb_reg_file;
    import reg_file_pkg::*;

    logic  clk = 1'b0;
    logic  reset;
    logic  AA1, BA1, WE, DA;
    word_t D_data, A_data, B_data;
    word_t mdl [2];
    int    n_cmp = 0;
    int    n_bad = 0;

    reg_file dut (
        .clk(clk), .reset(reset), .AA1(AA1), .BA1(BA1), .WE(WE),
        .DA(DA), .D_data(D_data), .A_data(A_data), .B_data(B_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input word_t obs, input word_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_both(input string tag);
        chk({tag, "_A"}, A_data, mdl[AA1]);
        chk({tag, "_B"}, B_data, mdl[BA1]);
    endtask

    task automatic mdl_reset();
        mdl[0] = 16'h00A5;
        mdl[1] = 16'h5A00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (WE === 1'b1 && reset === 1'b1) mdl[DA] = D_data;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; WE = 1'b0; AA1 = 1'b0; BA1 = 1'b1; DA = 1'b0; D_data = '0;
        mdl_reset();
        #52;
        chk("rst_A0", A_data, 16'h00A5);
        chk("rst_B1", B_data, 16'h5A00);
        BA1 = 1'b0;
        #48;
        reset = 1'b1;
        repeat (5) tick();

        to_neg(); AA1 = 1'b0; BA1 = 1'b0; #1;
        chk("r029_A", A_data, 16'h00A5);
        chk("r029_B", B_data, 16'h00A5);
        AA1 = 1'b1; BA1 = 1'b1; #1;
        chk("r030_A", A_data, 16'h5A00);
        chk("r030_B", B_data, 16'h5A00);
        AA1 = 1'b0; BA1 = 1'b1; #1;
        chk("r031a_A", A_data, 16'h00A5);
        chk("r031a_B", B_data, 16'h5A00);
        AA1 = 1'b1; BA1 = 1'b0; #1;
        chk("r031b_A", A_data, 16'h5A00);
        chk("r031b_B", B_data, 16'h00A5);

        to_neg(); WE = 1'b1; DA = 1'b1; D_data = 16'hBEEF; AA1 = 1'b1; BA1 = 1'b0; #1;
        chk("r032_pre", A_data, 16'h5A00);
        tick(); WE = 1'b0;
        chk("r032_post", A_data, 16'hBEEF);
        chk("r032_reg0", B_data, 16'h00A5);

        to_neg(); reset = 1'b0; #1;
        mdl_reset();
        chk("r033_A", A_data, 16'h5A00);
        chk("r033_B", B_data, 16'h00A5);
        WE = 1'b1; DA = 1'b0; D_data = 16'h1234; AA1 = 1'b0;
        tick();
        chk("rst_blocks_wr", A_data, 16'h00A5);
        to_neg(); WE = 1'b0; reset = 1'b1;
        repeat (5) tick();

        AA1 = 1'b0; BA1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            to_neg(); D_data = ~D_data ^ word_t'(i);
            tick();
            chk("r034_A", A_data, 16'h00A5);
            chk("r034_B", B_data, 16'h5A00);
        end

        to_neg(); WE = 1'b1; DA = 1'b0; D_data = 16'hFFFF; AA1 = 1'b0;
        #2 reset = 1'b0;
        mdl_reset();
        tick();
        chk("rst_override", A_data, 16'h00A5);
        to_neg(); WE = 1'b0; reset = 1'b1;
        repeat (5) tick();

        for (int i = 0; i < 300; i++) begin
            to_neg();
            WE = 1'($urandom); DA = 1'($urandom); D_data = word_t'($urandom);
            AA1 = 1'($urandom); BA1 = 1'($urandom);
            #1 chk_both("rnd_pre");
            tick();
            chk_both("rnd_post");
        end
        WE = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter NREGS, default 2, number of registers; address width AW = max(1, clog2(NREGS)).
REQ-003 Parameter RST_VAL0, default 16'h00A5, reset value of register 0.
REQ-004 Parameter RST_VAL1, default 16'h5A00, reset value of register 1; registers 2..NREGS-1 reset to 0.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-007 AA1  input  AW  read address, port A.
REQ-008 BA1  input  AW  read address, port B.
REQ-009 WE  input  1  write enable; tie to 0 when unused.
REQ-010 DA  input  AW  write address.
REQ-011 D_data  input  WIDTH  write data.
REQ-012 A_data  output  WIDTH  read data, port A.
REQ-013 B_data  output  WIDTH  read data, port B.

Function
REQ-014 Storage: NREGS registers of WIDTH bits each.
REQ-015 Reads combinational, zero latency: A_data = reg[AA1], B_data = reg[BA1], updating within the same cycle the address changes.
REQ-016 Both read ports independent; AA1 == BA1 returns the same value on both.
REQ-017 Write: on rising clk with WE=1 and reset deasserted, reg[DA] <= D_data; all other registers unchanged.
REQ-018 WE=0: no register changes; contents hold indefinitely.
REQ-019 Read-during-write to same address: reads return old value until the clock edge, new value immediately after.
REQ-020 Address >= NREGS (non-power-of-2 NREGS): reads return 0; writes ignored.
REQ-021 X/Z on WE treated as no write; X/Z on a read address produces X only on that port.
REQ-022 A_data/B_data never registered; no pipeline stages.

Reset
REQ-023 reset=0 immediately (no clock required) loads RST_VAL0 into reg 0, RST_VAL1 into reg 1, 0 elsewhere.
REQ-024 While reset=0, writes blocked; outputs reflect reset values at the addressed locations.
REQ-025 Reset asserted mid-operation overrides any pending write in that cycle.
REQ-026 Deassertion is synchronized so the first write takes effect no earlier than the second rising edge after reset rises.

Structure
REQ-027 Shared package holds WIDTH/NREGS defaults, reset-value constants and a word typedef.
REQ-028 Single module; no sub-modules; read muxes and write decode inline.

Verification
REQ-029 Reset=0 for 100 ns, then 1; AA1=0, BA1=0, WE=0 -> A_data=B_data=16'h00A5.
REQ-030 AA1=1, BA1=1 -> A_data=B_data=16'h5A00 same cycle.
REQ-031 AA1=0, BA1=1 then AA1=1, BA1=0 -> (16'h00A5, 16'h5A00) then (16'h5A00, 16'h00A5).
REQ-032 WE=1, DA=1, D_data=16'hBEEF, AA1=1 -> A_data 16'h5A00 before edge, 16'hBEEF after; reg 0 unchanged.
REQ-033 After REQ-032 write, pull reset=0 between edges -> outputs return to 16'h00A5/16'h5A00 asynchronously.
REQ-034 WE=0 with D_data toggling for 10 cycles -> outputs constant.
